lpc: RTL and testbench

LPC -- requirements
Module: lpc

---
 rtl/lpc.sv | 131 +++++++++++++
 tb/tb_lpc.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lpc.sv
// Passive LPC bus sniffer: decodes I/O (and, with LPC_MEM_CYCLE_EN, memory) read/write cycles.
// Latency: report strobe one clock after the 2nd read data nibble, or after SYNC=0000 on writes.
// Backpressure: none; it only observes the bus and never stalls or drives it.
module lpc (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic        lpc_frame,
    input  logic [3:0]  lpc_ad,
    output logic [3:0]  out_cyctype_dir,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [3:0]  out_data_size,
    output logic        out_clock_enable
);

    typedef enum logic [2:0] {IDLE, START, CYCTYPE, ADDR, TAR1, SYNC, DATA, TAR2} state_t;

    state_t      state;
    logic [3:0]  ct;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [2:0]  cnt;

    function automatic logic ct_ok(input logic [3:0] c);
`ifdef LPC_MEM_CYCLE_EN
        return (c[3] == 1'b0) && (c[0] == 1'b0);
`else
        return (c[3:2] == 2'b00) && (c[0] == 1'b0);
`endif
    endfunction

    always_ff @(posedge lpc_clock) begin
        if (lpc_reset) begin
            state            <= IDLE;
            ct               <= '0;
            addr             <= '0;
            data             <= '0;
            cnt              <= '0;
            out_cyctype_dir  <= '0;
            out_addr         <= '0;
            out_data         <= '0;
            out_data_size    <= '0;
            out_clock_enable <= 1'b0;
        end else begin
            out_clock_enable <= 1'b0;
            // LFRAME# low overrides everything: START on 0000, abort otherwise.
            if (!lpc_frame) begin
                cnt <= '0;
                if (lpc_ad == 4'h0) begin
                    state <= START;
                    addr  <= '0;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    START: begin
                        ct    <= lpc_ad;
                        cnt   <= '0;
                        state <= ct_ok(lpc_ad) ? ADDR : IDLE;
                    end
                    CYCTYPE: state <= IDLE;
                    ADDR: begin
                        addr <= {addr[27:0], lpc_ad};
                        if (cnt == (ct[2] ? 3'd7 : 3'd3)) begin
                            cnt   <= '0;
                            state <= ct[1] ? DATA : TAR1;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    TAR1: begin
                        if (cnt == 3'd1) begin
                            cnt   <= '0;
                            state <= SYNC;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    SYNC: begin
                        cnt <= '0;
                        if (lpc_ad == 4'h0) begin
                            if (ct[1]) begin
                                out_addr         <= addr;
                                out_data         <= {24'h0, data};
                                out_cyctype_dir  <= ct;
                                out_data_size    <= 4'd1;
                                out_clock_enable <= 1'b1;
                                state            <= TAR2;
                            end else begin
                                state <= DATA;
                            end
                        end else if (lpc_ad != 4'h5 && lpc_ad != 4'h6) begin
                            state <= IDLE;
                        end
                    end
                    DATA: begin
                        if (cnt == 3'd0) begin
                            data[3:0] <= lpc_ad;
                            cnt       <= 3'd1;
                        end else begin
                            data[7:4] <= lpc_ad;
                            cnt       <= '0;
                            if (ct[1]) begin
                                state <= TAR1;
                            end else begin
                                out_addr         <= addr;
                                out_data         <= {24'h0, lpc_ad, data[3:0]};
                                out_cyctype_dir  <= ct;
                                out_data_size    <= 4'd1;
                                out_clock_enable <= 1'b1;
                                state            <= TAR2;
                            end
                        end
                    end
                    TAR2: begin
                        if (cnt == 3'd1) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lpc.sv
// Directed + randomized bench for lpc; expected reports come from a cycle-level model of the LPC protocol.
module tb_lpc;
    logic        lpc_clock = 1'b0;
    logic        lpc_reset;
    logic        lpc_frame;
    logic [3:0]  lpc_ad;
    logic [3:0]  out_cyctype_dir;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  out_data_size;
    logic        out_clock_enable;

    lpc dut (
        .lpc_clock(lpc_clock), .lpc_reset(lpc_reset), .lpc_frame(lpc_frame), .lpc_ad(lpc_ad),
        .out_cyctype_dir(out_cyctype_dir), .out_addr(out_addr), .out_data(out_data),
        .out_data_size(out_data_size), .out_clock_enable(out_clock_enable)
    );

    always #15 lpc_clock = ~lpc_clock;

`ifdef LPC_MEM_CYCLE_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    // Expected held output values (last report).
    logic [31:0] h_addr = '0;
    logic [31:0] h_data = '0;
    logic [3:0]  h_ct   = '0;
    logic [3:0]  h_size = '0;

    logic [4:0]  seq[$];
    int          rep_idx;
    logic [31:0] p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_ct;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit supported(input logic [3:0] c);
        if (c[0] != 1'b0) return 1'b0;
        if (c[3:2] == 2'b00) return 1'b1;
        if (c[3:2] == 2'b01) return MEM_EN;
        return 1'b0;
    endfunction

    // Builds the nibble stream of one bus cycle; abort_at >= 0 aborts after that many address nibbles.
    task automatic build(input logic [3:0] c, input logic [31:0] a, input logic [7:0] d,
                         input int nwait, input int abort_at);
        int na;
        seq.delete();
        rep_idx = -1;
        seq.push_back({1'b0, 4'h0});
        seq.push_back({1'b1, c});
        if (!supported(c)) begin
            seq.push_back({1'b1, 4'hf});
            seq.push_back({1'b1, 4'hf});
            return;
        end
        na = c[2] ? 8 : 4;
        for (int n = na - 1; n >= 0; n--) begin
            if (abort_at == na - 1 - n) begin
                seq.push_back({1'b0, 4'hf});
                seq.push_back({1'b1, 4'hf});
                return;
            end
            seq.push_back({1'b1, a[4*n +: 4]});
        end
        if (!c[1]) begin
            seq.push_back({1'b1, 4'bzzzz});
            seq.push_back({1'b1, 4'bzzzz});
            for (int w = 0; w < nwait; w++)
                seq.push_back({1'b1, ($urandom_range(0, 1) == 1) ? 4'h5 : 4'h6});
            seq.push_back({1'b1, 4'h0});
            seq.push_back({1'b1, d[3:0]});
            rep_idx = seq.size();
            seq.push_back({1'b1, d[7:4]});
        end else begin
            seq.push_back({1'b1, d[3:0]});
            seq.push_back({1'b1, d[7:4]});
            seq.push_back({1'b1, 4'bzzzz});
            seq.push_back({1'b1, 4'bzzzz});
            for (int w = 0; w < nwait; w++)
                seq.push_back({1'b1, ($urandom_range(0, 1) == 1) ? 4'h5 : 4'h6});
            rep_idx = seq.size();
            seq.push_back({1'b1, 4'h0});
        end
        seq.push_back({1'b1, 4'bzzzz});
        seq.push_back({1'b1, 4'bzzzz});
        seq.push_back({1'b1, 4'hf});
        p_addr = c[2] ? a : {16'h0, a[15:0]};
        p_data = {24'h0, d};
        p_ct   = c;
    endtask

    task automatic check_held(input string tag);
        check({tag, "_addr"}, out_addr, h_addr);
        check({tag, "_data"}, out_data, h_data);
        check({tag, "_ct"}, {28'h0, out_cyctype_dir}, {28'h0, h_ct});
        check({tag, "_size"}, {28'h0, out_data_size}, {28'h0, h_size});
    endtask

    task automatic run(input string tag, input int stop_at);
        for (int i = 0; i < seq.size() && i < stop_at; i++) begin
            lpc_frame = seq[i][4];
            lpc_ad    = seq[i][3:0];
            @(posedge lpc_clock);
            #1;
            check({tag, "_strobe"}, {31'h0, out_clock_enable}, {31'h0, (i == rep_idx)});
            if (i == rep_idx) begin
                h_addr = p_addr;
                h_data = p_data;
                h_ct   = p_ct;
                h_size = 4'd1;
            end
        end
        check_held(tag);
    endtask

    initial begin
        logic [3:0] cts[7];
        logic [3:0] c;
        int         ab;
        cts = '{4'h0, 4'h2, 4'h4, 4'h6, 4'h8, 4'h1, 4'he};

        lpc_reset = 1'b1;
        lpc_frame = 1'b1;
        lpc_ad    = 4'hf;
        repeat (2) @(posedge lpc_clock);
        #1;
        check("reset_ce", {31'h0, out_clock_enable}, 32'h0);
        check_held("reset");
        lpc_reset = 1'b0;

        build(4'h0, 32'h0000_7fe5, 8'h6c, 0, -1);
        run("io_read", 1000);
        check("io_read_addr_val", out_addr, 32'h0000_7fe5);
        check("io_read_data_val", out_data, 32'h0000_006c);

        build(4'h2, 32'h0000_0080, 8'ha5, 0, -1);
        run("io_write", 1000);
        check("io_write_data_val", out_data, 32'h0000_00a5);

        build(4'h0, 32'h0000_1234, 8'h9e, 3, -1);
        run("sync_wait", 1000);

        build(4'h0, 32'h0000_abcd, 8'h11, 0, 2);
        run("abort", 1000);
        build(4'h2, 32'h0000_4321, 8'h77, 1, -1);
        run("after_abort", 1000);

        build(4'h4, 32'hffff_0010, 8'h3c, 0, -1);
        run("mem_read", 1000);

        build(4'h0, 32'h0000_5555, 8'h42, 0, -1);
        run("reset_mid", 10);
        lpc_ad    = seq[10][3:0];
        lpc_reset = 1'b1;
        @(posedge lpc_clock);
        #1;
        lpc_reset = 1'b0;
        h_addr = '0; h_data = '0; h_ct = '0; h_size = '0;
        check("reset_mid_ce", {31'h0, out_clock_enable}, 32'h0);
        check_held("reset_mid_out");
        lpc_frame = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lpc_ad = 4'(i);
            @(posedge lpc_clock);
            #1;
            check("reset_mid_nostrobe", {31'h0, out_clock_enable}, 32'h0);
        end

        for (int t = 0; t < 40; t++) begin
            c  = cts[$urandom_range(0, 6)];
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, c[2] ? 7 : 3) : -1;
            build(c, $urandom, 8'($urandom), $urandom_range(0, 3), ab);
            run("rand", 1000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
